mm_weight_loader: RTL and testbench

MM_WEIGHT_LOADER -- requirements
Module: mm_weight_loader

---
 rtl/mm_pkg.sv | 30 +++
 rtl/mm_weight_loader.sv | 164 ++++++++++++++++
 tb/tb_mm_weight_loader.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply datapath slice.
//
// Contents:
//   MM_DATA_W / MM_LANES / MM_WBUF_ADDR_W - default geometry of the weight path
//   MM_ROWS / MM_COLS / MM_ELEM_W         - matrix-unit array constants
//   wl_state_e                            - weight-loader FSM states
//   lane_idx_w()                          - width of a lane index, never zero
package mm_pkg;

    localparam int unsigned MM_ELEM_W      = 32;
    localparam int unsigned MM_ROWS        = 16;
    localparam int unsigned MM_COLS        = 16;

    // One stream beat carries one matrix row (MM_COLS elements).
    localparam int unsigned MM_DATA_W      = MM_ELEM_W * MM_COLS;
    localparam int unsigned MM_LANES       = MM_ROWS;
    localparam int unsigned MM_WBUF_ADDR_W = 13;

    typedef enum logic [1:0] {
        WL_IDLE,
        WL_FILL,
        WL_WRITE,
        WL_DONE
    } wl_state_e;

    function automatic int unsigned lane_idx_w(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/mm_weight_loader.sv
// mm_weight_loader: packs LANES consecutive DATA_W stream beats into one
// weight-buffer word and writes it at an auto-incrementing address.
//
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   start_valid            - one-cycle start pulse (honoured only when idle)
//   weight_start_addr      - first word address, sampled on start
//   beat_count             - total beats to load, sampled on start
//   in_data/in_valid/in_ready - input beat stream
//   wbuf_wr_en/_addr/_data - weight-buffer write port (addr/data held between writes)
//   busy                   - high whenever the FSM is not idle
//   done                   - one-cycle completion pulse
//
// Build option MM_WLOAD_ZERO_PAD_EN: when defined, a partial final word is
// written with its unfilled lanes zero; otherwise trailing beats that do not
// fill a word are consumed and dropped.
module mm_weight_loader
    import mm_pkg::*;
#(
    parameter int unsigned DATA_W = MM_DATA_W,
    parameter int unsigned LANES  = MM_LANES,
    parameter int unsigned ADDR_W = MM_WBUF_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_valid,
    input  logic [ADDR_W-1:0]         weight_start_addr,
    input  logic [15:0]               beat_count,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      wbuf_wr_en,
    output logic [ADDR_W-1:0]         wbuf_wr_addr,
    output logic [DATA_W*LANES-1:0]   wbuf_wr_data,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned LANE_W = lane_idx_w(LANES);
    localparam int unsigned WORD_W = DATA_W * LANES;

    wl_state_e             state_q, state_d;
    logic [15:0]           rem_q, rem_d;
    logic [LANE_W-1:0]     lane_q, lane_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0]     asm_q, asm_d;
    logic [WORD_W-1:0]     wr_data_q, wr_data_d;
    logic                  in_ready_q, in_ready_d;
    logic                  wr_en_q, wr_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  beat_acc;
    logic                  last_beat;
    logic                  lane_full;
    logic                  do_write;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        lane_d    = lane_q;
        addr_d    = addr_q;
        wr_addr_d = wr_addr_q;
        asm_d     = asm_q;
        wr_data_d = wr_data_q;
        do_write  = 1'b0;

        beat_acc  = (state_q == WL_FILL) && in_valid && in_ready_q;
        last_beat = (rem_q == 16'd1);
        lane_full = (lane_q == LANE_W'(LANES - 1));

        case (state_q)
            WL_IDLE: begin
                if (start_valid) begin
                    addr_d  = weight_start_addr;
                    rem_d   = beat_count;
                    lane_d  = '0;
                    asm_d   = '0;
                    state_d = (beat_count == 16'd0) ? WL_DONE : WL_FILL;
                end
            end
            WL_FILL: begin
                if (beat_acc) begin
                    asm_d[32'(lane_q) * DATA_W +: DATA_W] = in_data;
                    rem_d  = rem_q - 16'd1;
                    lane_d = lane_q + LANE_W'(1);
                    if (lane_full) begin
                        do_write = 1'b1;
                    end else if (last_beat) begin
`ifdef MM_WLOAD_ZERO_PAD_EN
                        do_write = 1'b1;
`else
                        asm_d   = '0;
                        lane_d  = '0;
                        state_d = WL_DONE;
`endif
                    end
                end
                // The outgoing word is captured including this cycle's beat;
                // the assembly register restarts from zero for the next word.
                if (do_write) begin
                    wr_data_d = asm_d;
                    wr_addr_d = addr_q;
                    addr_d    = addr_q + ADDR_W'(1);
                    asm_d     = '0;
                    lane_d    = '0;
                    state_d   = WL_WRITE;
                end
            end
            WL_WRITE: begin
                state_d = (rem_q != 16'd0) ? WL_FILL : WL_DONE;
            end
            WL_DONE: begin
                state_d = WL_IDLE;
            end
            default: begin
                state_d = WL_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they align with it.
        in_ready_d = (state_d == WL_FILL);
        wr_en_d    = (state_d == WL_WRITE);
        busy_d     = (state_d != WL_IDLE);
        done_d     = (state_d == WL_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WL_IDLE;
            rem_q      <= '0;
            lane_q     <= '0;
            addr_q     <= '0;
            wr_addr_q  <= '0;
            asm_q      <= '0;
            wr_data_q  <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            lane_q     <= lane_d;
            addr_q     <= addr_d;
            wr_addr_q  <= wr_addr_d;
            asm_q      <= asm_d;
            wr_data_q  <= wr_data_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign wbuf_wr_en   = wr_en_q;
    assign wbuf_wr_addr = wr_addr_q;
    assign wbuf_wr_data = wr_data_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_mm_weight_loader.sv
// Self-checking bench for mm_weight_loader (default geometry 512 x 16, 13-bit
// address). Expected writes come from a word-level model: word w, lane k holds
// beat w*16+k, or zero past the end of the load. Honours MM_WLOAD_ZERO_PAD_EN.
module tb_mm_weight_loader;

    localparam int DW = 512;
    localparam int LN = 16;
    localparam int AW = 13;
    localparam int WW = DW * LN;

`ifdef MM_WLOAD_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start_valid;
    logic [AW-1:0] weight_start_addr;
    logic [15:0]   beat_count;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          wbuf_wr_en;
    logic [AW-1:0] wbuf_wr_addr;
    logic [WW-1:0] wbuf_wr_data;
    logic          busy;
    logic          done;

    mm_weight_loader #(.DATA_W(DW), .LANES(LN), .ADDR_W(AW)) dut (
        .clk               (clk),
        .rst               (rst),
        .start_valid       (start_valid),
        .weight_start_addr (weight_start_addr),
        .beat_count        (beat_count),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .wbuf_wr_en        (wbuf_wr_en),
        .wbuf_wr_addr      (wbuf_wr_addr),
        .wbuf_wr_data      (wbuf_wr_data),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    typedef struct {
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
        int            cyc;
    } wr_t;

    wr_t           wq[$];
    int            cyc = 0;
    int            acc_count, last_acc_cyc, done_count, done_cyc, start_cyc;
    bit            ready_seen;
    bit            hold_ok = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [WW-1:0] prev_data;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (in_ready) ready_seen = 1'b1;
            if (in_valid && in_ready) begin
                acc_count++;
                last_acc_cyc = cyc;
            end
            if (wbuf_wr_en) begin
                wr_t w;
                w.addr = wbuf_wr_addr;
                w.data = wbuf_wr_data;
                w.cyc  = cyc;
                wq.push_back(w);
                chk(cyc == last_acc_cyc + 1, "write_latency", 64'(cyc), 64'(last_acc_cyc + 1));
                chk(!in_ready, "ready_in_write", 64'(in_ready), 64'd0);
            end else if (hold_ok) begin
                chk(wbuf_wr_addr == prev_addr && wbuf_wr_data == prev_data, "hold_addr_data",
                    64'(wbuf_wr_addr), 64'(prev_addr));
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
            if (start_valid && !busy) start_cyc = cyc;
            prev_addr = wbuf_wr_addr;
            prev_data = wbuf_wr_data;
            hold_ok   = 1'b1;
        end else begin
            hold_ok = 1'b0;
        end
    end

    task automatic clear_mon();
        wq.delete();
        acc_count    = 0;
        last_acc_cyc = -10;
        done_count   = 0;
        done_cyc     = -1;
        start_cyc    = -1;
        ready_seen   = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(!in_ready && !wbuf_wr_en && !busy && !done, {tag, "_ctrl"},
            64'({in_ready, wbuf_wr_en, busy, done}), 64'd0);
        chk(wbuf_wr_addr == '0, {tag, "_addr"}, 64'(wbuf_wr_addr), 64'd0);
        chk(wbuf_wr_data == '0, {tag, "_data"}, wbuf_wr_data[63:0], 64'd0);
    endtask

    // ---------------- driver + model ----------------
    logic [DW-1:0] dq[$];

    task automatic fill_data(input int n, input bit rnd);
        dq.delete();
        for (int i = 0; i < n; i++) begin
            logic [DW-1:0] v;
            if (rnd) begin
                for (int j = 0; j < DW / 32; j++) v[j*32 +: 32] = $urandom;
            end else begin
                v = DW'(i);
            end
            dq.push_back(v);
        end
    endtask

    // vmode: 0 = in_valid held high, 1 = toggling 1/0, 2 = random
    task automatic run_load(input logic [AW-1:0] a, input int n, input int vmode,
                            input bit poke, input int exp_w, input logic [AW-1:0] exp_last);
        int  i = 0;
        int  guard = 0;
        bit  acc;
        bit  tog = 1'b0;
        int  nw;
        int  exp_done;
        clear_mon();
        @(posedge clk); #1;
        weight_start_addr = a;
        beat_count        = 16'(n);
        start_valid       = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        while (i < n && guard < 2000) begin
            tog      = ~tog;
            in_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? tog : 1'($urandom_range(0, 1));
            in_data  = dq[i];
            if (poke && i == 5) begin
                start_valid       = 1'b1;
                beat_count        = 16'd0;
                weight_start_addr = '1;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            start_valid = 1'b0;
            if (acc) i++;
            guard++;
        end
        chk(i == n, "beats_driven", 64'(i), 64'(n));
        // Offer junk beats until done: none of them may be taken.
        in_valid = 1'b1;
        in_data  = '1;
        guard    = 0;
        while (done_count == 0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        nw = PAD ? (n + LN - 1) / LN : n / LN;
        chk(acc_count == n, "beats_accepted", 64'(acc_count), 64'(n));
        chk(done_count == 1, "done_pulses", 64'(done_count), 64'd1);
        chk(wq.size() == nw, "write_count_model", 64'(wq.size()), 64'(nw));
        if (exp_w >= 0) begin
            chk(wq.size() == exp_w, "write_count_table", 64'(wq.size()), 64'(exp_w));
            if (exp_w > 0 && wq.size() > 0)
                chk(wq[wq.size()-1].addr == exp_last, "last_addr_table",
                    64'(wq[wq.size()-1].addr), 64'(exp_last));
        end
        for (int w = 0; w < nw && w < wq.size(); w++) begin
            logic [WW-1:0] ew = '0;
            logic [WW-1:0] got = wq[w].data;
            logic [AW-1:0] ea = AW'((int'(a) + w) % (1 << AW));
            int bad = 0;
            for (int k = 0; k < LN; k++) begin
                if (w * LN + k < n) ew[k*DW +: DW] = dq[w*LN + k];
            end
            for (int k = LN - 1; k >= 0; k--) begin
                if (got[k*DW +: DW] != ew[k*DW +: DW]) bad = k;
            end
            chk(wq[w].addr == ea, $sformatf("wr_addr w%0d", w), 64'(wq[w].addr), 64'(ea));
            chk(got == ew, $sformatf("wr_data w%0d lane%0d", w, bad),
                got[bad*DW +: 64], ew[bad*DW +: 64]);
        end
        if (n == 0) begin
            exp_done = start_cyc + 1;
            chk(!ready_seen, "ready_zero_load", 64'(ready_seen), 64'd0);
        end else if ((PAD || n % LN == 0) && wq.size() > 0) begin
            exp_done = wq[wq.size()-1].cyc + 1;
        end else begin
            exp_done = last_acc_cyc + 1;
        end
        chk(done_cyc == exp_done, "done_timing", 64'(done_cyc), 64'(exp_done));
        chk(!busy, "idle_after_done", 64'(busy), 64'd0);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [AW-1:0] addr;
        int            n;
        int            vmode;
        bit            poke;
        int            exp_writes;
        logic [AW-1:0] exp_last;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{13'h0100, 32, 0, 1'b1, 2, 13'h0101};
        vecs[1] = '{13'h0100, 32, 1, 1'b0, 2, 13'h0101};
        vecs[2] = '{13'h1FFF, 32, 0, 1'b0, 2, 13'h0000};
        vecs[3] = '{13'h0005, 0,  0, 1'b0, 0, 13'h0000};
        vecs[4] = '{13'h0200, 20, 0, 1'b0, PAD ? 2 : 1, 13'h0200 + (PAD ? 13'd1 : 13'd0)};
        vecs[5] = '{13'h0AAA, 16, 2, 1'b0, 1, 13'h0AAA};
        vecs[6] = '{13'h0010, 3,  1, 1'b0, PAD ? 1 : 0, 13'h0010};

        rst = 1'b1;
        start_valid = 1'b0;
        weight_start_addr = '0;
        beat_count = '0;
        in_data = '0;
        in_valid = 1'b0;
        clear_mon();
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            fill_data(vecs[v].n, vecs[v].vmode == 2);
            run_load(vecs[v].addr, vecs[v].n, vecs[v].vmode, vecs[v].poke,
                     vecs[v].exp_writes, vecs[v].exp_last);
        end

        // Reset after 7 beats of a 32-beat load, then a clean 16-beat load.
        fill_data(32, 1'b0);
        clear_mon();
        @(posedge clk); #1;
        weight_start_addr = 13'h0300;
        beat_count        = 16'd32;
        start_valid       = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        in_valid    = 1'b1;
        in_data     = '0;
        for (int g = 0; g < 100 && acc_count < 7; g++) begin
            @(posedge clk); #1;
        end
        chk(acc_count == 7, "beats_before_reset", 64'(acc_count), 64'd7);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midload_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk(wq.size() == 0, "no_write_after_abort", 64'(wq.size()), 64'd0);
        chk(done_count == 0, "no_done_after_abort", 64'(done_count), 64'd0);
        fill_data(16, 1'b1);
        run_load(13'h0400, 16, 0, 1'b0, 1, 13'h0400);

        // Randomised loads against the model.
        for (int r = 0; r < 5; r++) begin
            int n = $urandom_range(1, 40);
            logic [AW-1:0] a = AW'($urandom);
            fill_data(n, 1'b1);
            run_load(a, n, 2, r[0], -1, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
